z_pc_unit: RTL and testbench

//  Registered program-counter unit for the MIPS datapath; successor to the combinational next-PC logic.

---
 rtl/z_pc_unit_pkg.sv | 24 ++
 rtl/z_pc_unit_if.sv | 37 +++
 rtl/z_pc_unit_ras.sv | 62 ++++++
 rtl/z_pc_unit.sv | 110 +++++++++++
 tb/tb_z_pc_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/z_pc_unit_pkg.sv
// Shared definitions for the program-counter unit: register numbers,
// default vectors, next-PC source encoding and the jump-target helper.
package z_pc_unit_pkg;

    localparam logic [4:0]  RA_REG         = 5'd31;
    localparam int          INST_W         = 32;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

    // Which source the next-PC mux selects this cycle.
    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_JR     = 3'd3,
        SEL_EXC    = 3'd4
    } pc_sel_e;

    // Low 28 bits of a J/JAL target: word index shifted to a byte address.
    function automatic logic [31:0] jump_low(input logic [25:0] target);
        return {4'b0000, target, 2'b00};
    endfunction

endpackage

// File: rtl/z_pc_unit_if.sv
// Bundle between the hazard/control unit (master) and the PC unit (slave).
// Control inputs are level signals sampled at the rising clock edge;
// there is no valid/ready handshake: stall is the only flow control and
// holds the PC and the return-address stack for the cycle it is high.
interface z_pc_unit_if #(
    parameter int AW    = 32,
    parameter int CNT_W = 16
) ();
    logic [31:0]      inst;
    logic             branch;
    logic             branch_ne;
    logic             zero;
    logic             jump;
    logic             link;
    logic             jump_reg;
    logic [AW-1:0]    rs_value;
    logic             exception;
    logic             stall;
    logic [AW-1:0]    pc;
    logic [AW-1:0]    next_pc;
    logic [AW-1:0]    ras_top;
    logic             ras_valid;
    logic             ras_miss;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output inst, branch, branch_ne, zero, jump, link, jump_reg,
               rs_value, exception, stall,
        input  pc, next_pc, ras_top, ras_valid, ras_miss, miss_cnt
    );

    modport slave (
        input  inst, branch, branch_ne, zero, jump, link, jump_reg,
               rs_value, exception, stall,
        output pc, next_pc, ras_top, ras_valid, ras_miss, miss_cnt
    );
endinterface

// File: rtl/z_pc_unit_ras.sv
// Return-address stack: circular buffer with a write pointer and an
// occupancy count. A push when full overwrites the oldest entry; a pop
// when empty does nothing. Flush wins over pop, pop wins over push.
module z_ras
    import z_pc_unit_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [AW-1:0] wdata,
    output logic [AW-1:0] top,
    output logic          valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top_idx;
    logic [CW-1:0] count;
    logic          do_push;

    // ptr points at the next free slot, so the top lives one below it.
    assign top_idx = ptr - PW'(1);
    assign valid   = (count != '0);
    assign top     = valid ? mem[top_idx] : '0;
    assign do_push = push & ~pop & ~flush;

    // Entry storage: written only on an effective push, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush) begin
            ptr   <= '0;
            count <= '0;
        end else if (pop) begin
            if (count != '0) begin
                ptr   <= top_idx;
                count <= count - CW'(1);
            end
        end else if (do_push) begin
            ptr <= ptr + PW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/z_pc_unit.sv
// Registered program counter with next-PC selection for sequential,
// BEQ/BNE, J/JAL, JR and exception flow, plus return-address prediction
// for JR $31 and a saturating mispredict counter.
module z_pc_unit
    import z_pc_unit_pkg::*;
#(
    parameter int          AW         = 32,
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int          RAS_DEPTH  = 4,
    parameter int          CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    z_pc_unit_if.slave bus
);
    logic [AW-1:0]    pc_q;
    logic [AW-1:0]    pc4;
    logic [AW-1:0]    boff;
    logic [AW-1:0]    btgt;
    logic [AW-1:0]    jtgt;
    logic [AW-1:0]    nxt;
    logic [AW-1:0]    ras_top;
    logic             ras_valid;
    logic             taken;
    logic             advance;
    logic             is_ret;
    logic             ras_push;
    logic             ras_pop;
    logic             miss;
    logic             miss_q;
    logic [CNT_W-1:0] miss_cnt_q;
    pc_sel_e          sel;

    assign pc4   = pc_q + AW'(4);
    assign boff  = {{(AW-18){bus.inst[15]}}, bus.inst[15:0], 2'b00};
    assign btgt  = pc4 + boff;
    // Upper AW-28 bits of a jump target come from the delay-slot address.
    assign jtgt  = (pc4 & ~AW'(32'h0FFF_FFFF)) | AW'(jump_low(bus.inst[25:0]));
    assign taken = bus.branch & (bus.zero ^ bus.branch_ne);

    // A stall never holds back an exception.
    assign advance = ~bus.stall | bus.exception;
    assign is_ret  = bus.jump_reg & (bus.inst[25:21] == RA_REG);

    // JR outranks J in the mux, so a JAL that loses to a JR does not push.
    assign ras_push = advance & ~bus.exception & bus.jump & bus.link & ~bus.jump_reg;
    assign ras_pop  = advance & ~bus.exception & is_ret;
    assign miss     = ras_pop & (~ras_valid | (ras_top != bus.rs_value));

    // Next-PC source selection by fixed priority.
    always_comb begin
        sel = SEL_SEQ;
        if (bus.exception)     sel = SEL_EXC;
        else if (bus.jump_reg) sel = SEL_JR;
        else if (bus.jump)     sel = SEL_JUMP;
        else if (taken)        sel = SEL_BRANCH;
    end

    // Next-PC mux driven by the selected source.
    always_comb begin
        nxt = pc4;
        case (sel)
            SEL_EXC:    nxt = AW'(EXC_VECTOR);
            SEL_JR:     nxt = bus.rs_value;
            SEL_JUMP:   nxt = jtgt;
            SEL_BRANCH: nxt = btgt;
            default:    nxt = pc4;
        endcase
    end

    z_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .flush (bus.exception),
        .wdata (pc4),
        .top   (ras_top),
        .valid (ras_valid)
    );

    // PC register, one-cycle mispredict pulse and saturating miss count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= AW'(RESET_PC);
            miss_q     <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            if (advance) begin
                pc_q <= nxt;
            end
            miss_q <= miss;
            if (miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.next_pc   = nxt;
    assign bus.ras_top   = ras_top;
    assign bus.ras_valid = ras_valid;
    assign bus.ras_miss  = miss_q;
    assign bus.miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_z_pc_unit.sv
// Bench for z_pc_unit: directed scenarios followed by random traffic,
// all checked against a queue-based model of the PC and return stack.
module tb_z_pc_unit;
    import z_pc_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    z_pc_unit_if #(.AW(32), .CNT_W(16)) bus ();

    z_pc_unit #(
        .AW         (32),
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0080),
        .RAS_DEPTH  (4),
        .CNT_W      (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Stimulus variables
    logic [31:0] t_inst;
    logic        t_br, t_bne, t_zero, t_j, t_lk, t_jr, t_exc, t_stall;
    logic [31:0] t_rv;

    assign bus.inst      = t_inst;
    assign bus.branch    = t_br;
    assign bus.branch_ne = t_bne;
    assign bus.zero      = t_zero;
    assign bus.jump      = t_j;
    assign bus.link      = t_lk;
    assign bus.jump_reg  = t_jr;
    assign bus.rs_value  = t_rv;
    assign bus.exception = t_exc;
    assign bus.stall     = t_stall;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] ras_q[$];
    logic [15:0] m_cnt;
    logic        m_miss;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        t_inst = 32'h0; t_br = 0; t_bne = 0; t_zero = 0; t_j = 0; t_lk = 0;
        t_jr = 0; t_rv = 32'h0; t_exc = 0; t_stall = 0;
    endtask

    function automatic logic [31:0] m_top();
        return (ras_q.size() > 0) ? ras_q[ras_q.size()-1] : 32'h0;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; ras_q.delete(); m_cnt = 16'h0; m_miss = 1'b0;
    endtask

    // One clock: predict, check next_pc, clock, update model, check state.
    task automatic cycle();
        logic [31:0] pc4, btgt, jtgt, nxt;
        int          off;
        bit          ret, hit;
        pc4  = m_pc + 32'd4;
        off  = int'($signed(t_inst[15:0]));
        btgt = pc4 + 32'(off * 4);
        jtgt = {pc4[31:28], t_inst[25:0], 2'b00};
        if (t_exc)                           nxt = 32'h0000_0080;
        else if (t_jr)                       nxt = t_rv;
        else if (t_j)                        nxt = jtgt;
        else if (t_br && (t_zero != t_bne))  nxt = btgt;
        else                                 nxt = pc4;
        #1;
        chk("next_pc", bus.next_pc, nxt);
        @(posedge clk);
        #1;
        m_miss = 1'b0;
        if (t_exc) begin
            m_pc = nxt;
            ras_q.delete();
        end else if (!t_stall) begin
            m_pc = nxt;
            ret  = t_jr && (t_inst[25:21] == 5'd31);
            if (ret) begin
                hit = (ras_q.size() > 0) && (m_top() == t_rv);
                if (ras_q.size() > 0) void'(ras_q.pop_back());
                if (!hit) begin
                    m_miss = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt++;
                end
            end else if (t_j && t_lk && !t_jr) begin
                ras_q.push_back(pc4);
                if (ras_q.size() > 4) void'(ras_q.pop_front());
            end
        end
        chk("pc", bus.pc, m_pc);
        chk("ras_valid", {31'h0, bus.ras_valid}, {31'h0, ras_q.size() > 0});
        chk("ras_top", bus.ras_top, m_top());
        chk("ras_miss", {31'h0, bus.ras_miss}, {31'h0, m_miss});
        chk("miss_cnt", {16'h0, bus.miss_cnt}, {16'h0, m_cnt});
    endtask

    // Move the PC with a JR through a non-return register.
    task automatic set_pc(input logic [31:0] a);
        clear_in(); t_jr = 1; t_rv = a; t_inst = 32'h0;
        cycle();
    endtask

    task automatic do_jal();
        clear_in(); t_j = 1; t_lk = 1; t_inst = 32'h0C00_0000 | 32'h40;
        cycle();
    endtask

    task automatic do_ret(input logic [31:0] rv);
        clear_in(); t_jr = 1; t_rv = rv; t_inst = {6'h0, 5'd31, 21'h8};
        cycle();
    endtask

    initial begin
        logic [31:0] jal_pc [5];
        logic [31:0] pops [4];
        logic [15:0] cnt_before;
        int          r;
        jal_pc = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
        pops   = '{32'h54, 32'h44, 32'h34, 32'h24};
        clear_in();
        model_reset();
        #12 rst = 1'b0;
        #1;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_ras_valid", {31'h0, bus.ras_valid}, 32'h0);
        chk("rst_miss_cnt", {16'h0, bus.miss_cnt}, 32'h0);
        chk("rst_ras_miss", {31'h0, bus.ras_miss}, 32'h0);
        @(posedge clk); #1;

        // Branch taken and not taken
        set_pc(32'h100);
        clear_in(); t_inst = 32'h1000_FFFE; t_br = 1; t_zero = 1; cycle();
        chk("beq_taken", bus.pc, 32'h0000_00FC);
        set_pc(32'h100);
        clear_in(); t_inst = 32'h1000_FFFE; t_br = 1; t_zero = 0; cycle();
        chk("beq_not_taken", bus.pc, 32'h0000_0104);
        set_pc(32'h100);
        clear_in(); t_inst = 32'h1400_0003; t_br = 1; t_bne = 1; t_zero = 0; cycle();
        chk("bne_taken", bus.pc, 32'h0000_0110);

        // Jump and stalled jump
        set_pc(32'h1000_0010);
        clear_in(); t_j = 1; t_inst = 32'h0800_0040; cycle();
        chk("jump", bus.pc, 32'h1000_0100);
        set_pc(32'h1000_0010);
        clear_in(); t_j = 1; t_stall = 1; t_inst = 32'h0800_0040; cycle();
        chk("jump_stalled", bus.pc, 32'h1000_0010);

        // RAS hit then miss on empty
        set_pc(32'h200);
        do_jal();
        chk("jal_top", bus.ras_top, 32'h204);
        do_ret(32'h204);
        chk("ret_hit_miss", {31'h0, bus.ras_miss}, 32'h0);
        do_ret(32'h204);
        chk("ret_empty_miss", {31'h0, bus.ras_miss}, 32'h1);
        chk("ret_empty_cnt", {16'h0, bus.miss_cnt}, 32'h1);
        clear_in(); cycle();
        chk("miss_pulse_end", {31'h0, bus.ras_miss}, 32'h0);

        // RAS overflow keeps the newest four
        for (int i = 0; i < 5; i++) begin
            set_pc(jal_pc[i]);
            do_jal();
        end
        for (int i = 0; i < 4; i++) begin
            chk("ovf_top", bus.ras_top, pops[i]);
            do_ret(pops[i]);
            chk("ovf_hit", {31'h0, bus.ras_miss}, 32'h0);
        end
        do_ret(32'h14);
        chk("ovf_fifth_miss", {31'h0, bus.ras_miss}, 32'h1);
        chk("ovf_cnt", {16'h0, bus.miss_cnt}, 32'h2);

        // Exception beats stall, jump and jump_reg, and flushes the RAS
        set_pc(32'h300);
        do_jal();
        clear_in(); t_exc = 1; t_stall = 1; t_j = 1; t_jr = 1; t_rv = 32'h444;
        t_inst = {6'h0, 5'd31, 21'h8};
        cycle();
        chk("exc_pc", bus.pc, 32'h80);
        chk("exc_ras_valid", {31'h0, bus.ras_valid}, 32'h0);
        chk("exc_cnt_kept", {16'h0, bus.miss_cnt}, 32'h2);

        // Sequential wrap
        set_pc(32'hFFFF_FFFC);
        clear_in(); cycle();
        chk("wrap", bus.pc, 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            clear_in();
            t_inst = $urandom();
            r = $urandom_range(0, 99);
            if (r < 25) begin
                // sequential
            end else if (r < 45) begin
                t_br = 1; t_bne = 1'($urandom_range(0, 1)); t_zero = 1'($urandom_range(0, 1));
            end else if (r < 65) begin
                t_j = 1; t_lk = 1'($urandom_range(0, 2) != 0);
            end else if (r < 90) begin
                t_jr = 1;
                if ($urandom_range(0, 9) < 7) t_inst[25:21] = 5'd31;
                if (ras_q.size() > 0 && $urandom_range(0, 1) == 1) t_rv = m_top();
                else t_rv = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            end else begin
                t_exc = 1;
            end
            if ($urandom_range(0, 9) == 0) t_j = 1;
            if ($urandom_range(0, 19) == 0) t_jr = 1;
            t_stall = ($urandom_range(0, 6) == 0);
            cycle();
        end

        // Asynchronous reset between clock edges
        cnt_before = m_cnt;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pc", bus.pc, 32'h0);
        chk("async_rst_ras_valid", {31'h0, bus.ras_valid}, 32'h0);
        chk("async_rst_miss_cnt", {16'h0, bus.miss_cnt}, 32'h0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        clear_in();
        cycle();
        chk("post_rst_seq", bus.pc, 32'h4);
        if (cnt_before == 16'h0) chk("pre_rst_cnt_nonzero", 32'h1, {16'h0, cnt_before});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
